// File: rtl/full_handshake_rx_mc_if.sv
// Bundle of the per-channel 4-phase inbound links and the merged valid/ready output stream.
// master: the receiver block; slave: the TX-side peripherals plus the downstream consumer.
`timescale 1ns/1ps

interface full_handshake_rx_mc_if #(
    parameter int DW     = 32,
    parameter int NUM_CH = 4
);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic [NUM_CH-1:0]    req_i;
    logic [NUM_CH*DW-1:0] req_data_i;
    logic [NUM_CH-1:0]    ack_o;
    logic                 out_valid_o;
    logic [DW-1:0]        out_data_o;
    logic [CH_W-1:0]      out_ch_o;
    logic                 out_ready_i;
    logic [NUM_CH-1:0]    err_o;

    modport master (
        input  req_i, req_data_i, out_ready_i,
        output ack_o, out_valid_o, out_data_o, out_ch_o, err_o
    );

    modport slave (
        output req_i, req_data_i, out_ready_i,
        input  ack_o, out_valid_o, out_data_o, out_ch_o, err_o
    );
endinterface

// File: rtl/full_handshake_rx_mc.sv
// Multi-channel 4-phase req/ack receiver merged into one valid/ready stream by a round-robin arbiter.
// Optional macro FULL_HS_RX_MC_TIMEOUT_EN adds per-channel sticky timeout flags on err_o.
`timescale 1ns/1ps

module full_handshake_rx_mc #(
    parameter int DW          = 32,
    parameter int NUM_CH      = 4,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    full_handshake_rx_mc_if.master bus
);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    // One-hot state bit positions
    localparam int ST_IDLE = 0;
    localparam int ST_PEND = 1;
    localparam int ST_ACK  = 2;
    localparam logic [2:0] S_IDLE = 3'b001;
    localparam logic [2:0] S_PEND = 3'b010;
    localparam logic [2:0] S_ACK  = 3'b100;

    logic [NUM_CH-1:0]    req_s;
    logic [NUM_CH-1:0]    pend;
    logic [NUM_CH*DW-1:0] buf_flat;

    logic            out_valid_reg;
    logic [DW-1:0]   out_data_reg;
    logic [CH_W-1:0] out_ch_reg;
    logic [CH_W-1:0] rr_ptr_reg;

    logic            out_free;
    logic            grant_valid;
    logic [CH_W-1:0] grant_idx;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            logic [SYNC_STAGES-1:0] sync_reg;
            logic [2:0]             st_reg;
            logic [2:0]             st_next;
            logic [DW-1:0]          buf_reg;
            logic                   granted;
            logic                   capture_w;
            logic                   pend_w;
            logic                   ack_w;

            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    sync_reg <= '0;
                end else begin
                    sync_reg <= {sync_reg[SYNC_STAGES-2:0], bus.req_i[gi]};
                end
            end
            assign req_s[gi] = sync_reg[SYNC_STAGES-1];

            assign granted = grant_valid && (grant_idx == CH_W'(gi));

            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    st_reg <= S_IDLE;
                end else begin
                    st_reg <= st_next;
                end
            end

            // Any non one-hot encoding falls back to IDLE
            always_comb begin
                st_next = st_reg;
                if (st_reg == S_IDLE) begin
                    if (req_s[gi]) st_next = S_PEND;
                end else if (st_reg == S_PEND) begin
                    if (granted) st_next = S_ACK;
                end else if (st_reg == S_ACK) begin
                    if (!req_s[gi]) st_next = S_IDLE;
                end else begin
                    st_next = S_IDLE;
                end
            end

            always_comb begin
                capture_w = st_reg[ST_IDLE] & req_s[gi];
                pend_w    = st_reg[ST_PEND];
                ack_w     = st_reg[ST_ACK];
            end

            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    buf_reg <= '0;
                end else if (capture_w) begin
                    buf_reg <= bus.req_data_i[gi*DW +: DW];
                end
            end

            assign pend[gi]                = pend_w;
            assign buf_flat[gi*DW +: DW]   = buf_reg;
            // The ACK state bit is itself the registered ack
            assign bus.ack_o[gi]           = ack_w;

`ifdef FULL_HS_RX_MC_TIMEOUT_EN
            localparam int TW = $clog2(TIMEOUT_CYC + 1);
            logic [TW-1:0] to_cnt_reg;
            logic          err_reg;

            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    to_cnt_reg <= '0;
                    err_reg    <= 1'b0;
                end else if (ack_w && req_s[gi]) begin
                    if (to_cnt_reg == TW'(TIMEOUT_CYC - 1)) begin
                        err_reg <= 1'b1;
                    end else begin
                        to_cnt_reg <= to_cnt_reg + 1'b1;
                    end
                end else begin
                    to_cnt_reg <= '0;
                end
            end
            assign bus.err_o[gi] = err_reg;
`else
            assign bus.err_o[gi] = 1'b0;
`endif
        end
    endgenerate

    assign out_free = !out_valid_reg || bus.out_ready_i;

    // First PEND channel at or after the rr pointer, wrapping
    always_comb begin
        int idx;
        idx         = 0;
        grant_valid = 1'b0;
        grant_idx   = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            idx = int'(rr_ptr_reg) + k;
            if (idx >= NUM_CH) idx = idx - NUM_CH;
            if (out_free && !grant_valid && pend[idx]) begin
                grant_valid = 1'b1;
                grant_idx   = CH_W'(idx);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
            out_ch_reg    <= '0;
            rr_ptr_reg    <= '0;
        end else if (grant_valid) begin
            out_valid_reg <= 1'b1;
            out_data_reg  <= buf_flat[grant_idx*DW +: DW];
            out_ch_reg    <= grant_idx;
            rr_ptr_reg    <= (int'(grant_idx) == NUM_CH - 1) ? '0 : grant_idx + 1'b1;
        end else if (bus.out_ready_i) begin
            out_valid_reg <= 1'b0;
        end
    end

    assign bus.out_valid_o = out_valid_reg;
    assign bus.out_data_o  = out_data_reg;
    assign bus.out_ch_o    = out_ch_reg;
endmodule

// File: tb/tb_full_handshake_rx_mc.sv
// Self-checking bench for full_handshake_rx_mc: vector table with a word scoreboard plus corner sequences.
`timescale 1ns/1ps

module tb_full_handshake_rx_mc;
    localparam int DW  = 32;
    localparam int NCH = 4;
    localparam int SS  = 2;
`ifdef FULL_HS_RX_MC_TIMEOUT_EN
    localparam int         TO      = 16;
    localparam logic [3:0] ERR_EXP = 4'b0001;
`else
    localparam int         TO      = 1024;
    localparam logic [3:0] ERR_EXP = 4'b0000;
`endif

    logic clk_i = 1'b0;
    logic rst_i;
    always #5 clk_i = ~clk_i;

    full_handshake_rx_mc_if #(.DW(DW), .NUM_CH(NCH)) bus ();

    full_handshake_rx_mc #(
        .DW(DW), .NUM_CH(NCH), .SYNC_STAGES(SS), .TIMEOUT_CYC(TO)
    ) dut (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .bus  (bus)
    );

    typedef struct packed {
        logic [1:0]  ch;
        logic [31:0] data;
    } exp_t;

    typedef struct {
        logic [3:0]      mask;
        logic [31:0]     base;
        int              n;
        logic [3:0][1:0] order;
    } vec_t;

    exp_t exp_q[$];
    vec_t vecs[9];
    int   total = 0;
    int   bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Every word accepted by the consumer must match the head of the scoreboard
    task automatic mon_sample();
        exp_t e;
        if (!rst_i && bus.out_valid_o && bus.out_ready_i) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_word actual=ch%0d/%h required=none", bus.out_ch_o, bus.out_data_o);
            end else begin
                e = exp_q.pop_front();
                if (bus.out_ch_o !== e.ch || bus.out_data_o !== e.data) begin
                    bad++;
                    $display("FAIL out_word actual=ch%0d/%h required=ch%0d/%h",
                             bus.out_ch_o, bus.out_data_o, e.ch, e.data);
                end else begin
                    $display("word ch%0d data=%h", e.ch, e.data);
                end
            end
        end
    endtask

    task automatic tick();
        @(negedge clk_i);
        mon_sample();
        @(posedge clk_i);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic push(input int ch, input logic [31:0] data);
        exp_t e;
        e.ch   = 2'(ch);
        e.data = data;
        exp_q.push_back(e);
    endtask

    task automatic wait_ack(input logic [3:0] mask, input logic val, input string name);
        logic [3:0] want;
        want = val ? mask : 4'b0000;
        for (int i = 0; i < 60; i++) begin
            if ((bus.ack_o & mask) == want) break;
            tick();
        end
        check(name, bus.ack_o & mask, want);
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 100; i++) begin
            if (exp_q.size() == 0) break;
            tick();
        end
        check(name, exp_q.size(), 0);
    endtask

    task automatic do_reset();
        rst_i      = 1'b1;
        bus.req_i  = '0;
        ticks(3);
        rst_i      = 1'b0;
    endtask

    function automatic vec_t mk(input logic [3:0] m, input logic [31:0] b, input int n,
                                input int o0, input int o1, input int o2, input int o3);
        vec_t v;
        v.mask     = m;
        v.base     = b;
        v.n        = n;
        v.order[0] = 2'(o0);
        v.order[1] = 2'(o1);
        v.order[2] = 2'(o2);
        v.order[3] = 2'(o3);
        return v;
    endfunction

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          raised[4];
        int          dcnt;
        int          held_bad;
        int          vcount;
        logic [31:0] d;

        // Grant orders follow from the rr pointer after each burst (starting at 0 after reset)
        vecs[0] = mk(4'b0001, 32'h0000_0100, 1, 0, 0, 0, 0);
        vecs[1] = mk(4'b1000, 32'h0000_0200, 1, 3, 0, 0, 0);
        vecs[2] = mk(4'b1111, 32'h0000_0010, 4, 0, 1, 2, 3);
        vecs[3] = mk(4'b1111, 32'h0000_0010, 4, 0, 1, 2, 3);
        vecs[4] = mk(4'b0110, 32'h0000_0300, 2, 1, 2, 0, 0);
        vecs[5] = mk(4'b0101, 32'h0000_0400, 2, 0, 2, 0, 0);
        vecs[6] = mk(4'b1100, 32'h0000_0500, 2, 3, 2, 0, 0);
        vecs[7] = mk(4'b1011, 32'h0000_0600, 3, 3, 0, 1, 0);
        vecs[8] = mk(4'b0111, 32'h0000_0700, 3, 2, 0, 1, 0);

        rst_i           = 1'b1;
        bus.req_i       = '0;
        bus.req_data_i  = '0;
        bus.out_ready_i = 1'b1;
        ticks(3);
        check("rst_ack",   bus.ack_o, 0);
        check("rst_valid", bus.out_valid_o, 0);
        check("rst_err",   bus.err_o, 0);
        check("rst_data",  bus.out_data_o, 0);
        check("rst_ch",    bus.out_ch_o, 0);
        rst_i = 1'b0;
        tick();

        // Single word latency: req before edge 0, output and ack after edge 3
        bus.req_data_i[0 +: DW] = 32'hDEAD_BEEF;
        push(0, 32'hDEAD_BEEF);
        bus.req_i[0] = 1'b1;
        ticks(3);
        check("lat_early_valid", bus.out_valid_o, 0);
        check("lat_early_ack",   bus.ack_o[0], 0);
        tick();
        check("lat_valid", bus.out_valid_o, 1);
        check("lat_ack",   bus.ack_o[0], 1);
        check("lat_ch",    bus.out_ch_o, 0);
        check("lat_data",  bus.out_data_o, 32'hDEAD_BEEF);
        bus.req_i[0] = 1'b0;
        ticks(2);
        check("ackfall_hold", bus.ack_o[0], 1);
        tick();
        check("ackfall", bus.ack_o[0], 0);
        wait_drain("lat_drain");

        // Backpressure: word held stable, no second word while req stays high
        bus.out_ready_i = 1'b0;
        bus.req_data_i[2*DW +: DW] = 32'h1234_5678;
        push(2, 32'h1234_5678);
        bus.req_i[2] = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (bus.out_valid_o) break;
            tick();
        end
        check("bp_valid", bus.out_valid_o, 1);
        held_bad = 0;
        for (int i = 0; i < 20; i++) begin
            if (!(bus.out_valid_o && bus.out_data_o == 32'h1234_5678 && bus.out_ch_o == 2'd2 && bus.ack_o[2]))
                held_bad++;
            tick();
        end
        check("bp_hold_cycles_bad", held_bad, 0);
        bus.out_ready_i = 1'b1;
        ticks(3);
        check("bp_single_word", bus.out_valid_o, 0);
        check("bp_ack_held",    bus.ack_o[2], 1);
        bus.req_i[2] = 1'b0;
        wait_ack(4'b0100, 1'b0, "bp_ack_fall");
        wait_drain("bp_drain");

        // Vector table: bursts on channel masks, expected rr grant order
        do_reset();
        for (int v = 0; v < 9; v++) begin
            for (int c = 0; c < NCH; c++)
                if (vecs[v].mask[c]) bus.req_data_i[c*DW +: DW] = vecs[v].base + 32'(c);
            for (int k = 0; k < vecs[v].n; k++)
                push(int'(vecs[v].order[k]), vecs[v].base + 32'(vecs[v].order[k]));
            bus.req_i = vecs[v].mask;
            wait_ack(vecs[v].mask, 1'b1, "vec_ack_rise");
            bus.req_i = '0;
            wait_ack(vecs[v].mask, 1'b0, "vec_ack_fall");
            wait_drain("vec_drain");
        end

        // Fairness: ch1 and ch3 re-request continuously as 4-phase TX agents
        do_reset();
        raised = '{0, 0, 0, 0};
        dcnt   = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            for (int c = 1; c < NCH; c += 2) begin
                if (!bus.req_i[c] && !bus.ack_o[c] && raised[c] < 4) begin
                    d = 32'hF000_0000 + 32'(dcnt);
                    dcnt++;
                    bus.req_data_i[c*DW +: DW] = d;
                    push(c, d);
                    bus.req_i[c] = 1'b1;
                    raised[c]++;
                end else if (bus.req_i[c] && bus.ack_o[c]) begin
                    bus.req_i[c] = 1'b0;
                end
            end
            if (raised[1] == 4 && raised[3] == 4 && bus.req_i == '0 && bus.ack_o == '0) break;
            tick();
        end
        check("fair_idle_ack", bus.ack_o, 0);
        wait_drain("fair_drain");

        // Reset while ch2 is in ACK (word stuck in output) and ch1 is PEND
        do_reset();
        bus.out_ready_i = 1'b0;
        bus.req_data_i[2*DW +: DW] = 32'hAAAA_0002;
        bus.req_data_i[1*DW +: DW] = 32'hAAAA_0001;
        bus.req_i[2] = 1'b1;
        wait_ack(4'b0100, 1'b1, "mid_ack2");
        bus.req_i[1] = 1'b1;
        ticks(4);
        check("mid_pre_valid", bus.out_valid_o, 1);
        rst_i = 1'b1;
        tick();
        check("mid_rst_ack",   bus.ack_o, 0);
        check("mid_rst_valid", bus.out_valid_o, 0);
        check("mid_rst_err",   bus.err_o, 0);
        bus.req_i = '0;
        ticks(2);
        rst_i = 1'b0;
        bus.out_ready_i = 1'b1;
        vcount = 0;
        for (int i = 0; i < 10; i++) begin
            if (bus.out_valid_o) vcount++;
            tick();
        end
        check("mid_no_word_cycles", vcount, 0);

        // Timeout: ch0 req held high 40 cycles after ack
        bus.req_data_i[0 +: DW] = 32'h7070_0000;
        push(0, 32'h7070_0000);
        bus.req_i[0] = 1'b1;
        wait_ack(4'b0001, 1'b1, "to_ack");
        ticks(10);
        check("to_err_early", bus.err_o, 0);
        ticks(30);
        check("to_err_set", bus.err_o, ERR_EXP);
        bus.req_i[0] = 1'b0;
        wait_ack(4'b0001, 1'b0, "to_ack_fall");
        ticks(2);
        check("to_err_sticky", bus.err_o, ERR_EXP);
        wait_drain("to_drain");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
